quiz_round_ctrl: RTL and testbench
==================================

Name: quiz_round_ctrl

Overview:
Game-round sequencer for the quick-math player, directly upstream of the 8-bit ALU. It generates pseudo-random operands and a one-hot operation select, and drives them to the ALU's A/B/MODE inputs. It consumes the ALU's combinational RES and checks it against the player's switch answer under a per-round countdown. It also keeps the score across a fixed number of rounds.

Parameters:
ROUNDS, 8, questions per game (1..15)
TICKS_PER_SEC, 50000000, CLK cycles per countdown second (>=2)
ROUND_SECONDS, 10, seconds allowed per question (1..15)
LFSR_SEED, 16'hACE1, operand LFSR reset value; 0 is replaced by 16'hACE1

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous, active-high reset
START  input  1  one-cycle pulse; begins a game from IDLE or OVER
SUBMIT  input  1  one-cycle pulse; player commits ANSWER
ANSWER  input  8  player answer (switches), sampled on SUBMIT
RES  input  8  ALU result for current A/B/MODE
A  output  8  operand A to ALU
B  output  8  operand B to ALU
MODE  output  4  one-hot op to ALU: 1000 add, 0100 sub, 0010 xor, 0001 shift-left A
SCORE  output  5  correct answers this game
ROUND  output  4  current question number, 1..ROUNDS; 0 when idle
TIME_LEFT  output  4  seconds remaining in current question
BUSY  output  1  high in GEN/ASK/JUDGE
CORRECT  output  1  one-cycle pulse: answer matched
WRONG  output  1  one-cycle pulse: answer mismatched or timed out
DONE  output  1  high in OVER

Behaviour:
- Single clock domain. RST is synchronous, active-high, and overrides everything, including mid-game. On reset: state IDLE, A=B=0, MODE=0000, SCORE=0, ROUND=0, TIME_LEFT=0, BUSY=CORRECT=WRONG=DONE=0, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1. Shifts left every cycle from reset, in all states. New bit0 = q15^q13^q12^q10.
- State IDLE: waits for START, then goes to GEN with ROUND=1 and SCORE=0.
- State GEN: lasts 1 cycle.
  - Registers A=lfsr[7:0], B=lfsr[15:8].
  - MODE comes from lfsr[9:8]: 00->1000, 01->0100, 10->0010, 11->0001.
  - Loads TIME_LEFT=ROUND_SECONDS and clears the tick counter. Next state is ASK.
- State ASK:
  - A/B/MODE are held stable, so RES is valid from the first ASK cycle.
  - The tick counter counts 0..TICKS_PER_SEC-1; on wrap, TIME_LEFT decrements.
  - SUBMIT latches ANSWER into an internal register; next state is JUDGE (answered).
  - When TIME_LEFT=1 and the tick wraps, next state is JUDGE (timeout). Unanswered ASK therefore lasts exactly TICKS_PER_SEC*ROUND_SECONDS cycles.
  - SUBMIT in the same cycle as the timeout wrap counts as answered.
- State JUDGE: lasts 1 cycle.
  - Answered and latched answer == RES: CORRECT pulses and SCORE increments.
  - Otherwise (mismatch or timeout): WRONG pulses and SCORE is held.
  - The pulse and the SCORE change become visible on the cycle after JUDGE and last exactly 1 cycle.
  - If ROUND==ROUNDS, next state is OVER. Otherwise ROUND increments and next state is GEN.
- State OVER: DONE=1, BUSY=0; A/B/MODE/SCORE/ROUND are held. START goes to GEN exactly as from IDLE.
- START and SUBMIT are ignored outside the states listed above. SUBMIT outside ASK has no effect.
- All arithmetic is 8-bit modulo; the comparison is an exact 8-bit equality. SCORE never wraps (max ROUNDS, plus bonus).
- All outputs are registered.

Optional Feature:
Macro STREAK_BONUS_EN.
- Defined: a 2-bit streak counter counts consecutive correct answers.
  - On the 3rd consecutive correct, SCORE increments by 2 and the streak clears.
  - A wrong answer or timeout clears the streak; START and reset clear it.
  - Max SCORE = ROUNDS + ROUNDS/3.
- Undefined: no streak logic; every correct answer adds exactly 1.

Test Plan:
1. Reset then idle: RST high 2 cycles -> all outputs 0 / MODE=0000. With no START for 100 cycles -> state stays IDLE, BUSY=0.
2. Correct answer: TICKS_PER_SEC=4, ROUND_SECONDS=3; START; in ASK drive ANSWER=RES (e.g. A=0x37, B=0x12, MODE=0100 -> 0x25) and pulse SUBMIT -> CORRECT for 1 cycle, SCORE 0->1, ROUND 1->2.
3. Timeout: same parameters, no SUBMIT -> ASK lasts exactly 12 cycles, TIME_LEFT steps 3,2,1, then WRONG pulse, SCORE unchanged. SUBMIT on the final wrap cycle -> judged as an answer instead.
4. Full game: ROUNDS=8, answer 5 correct and 3 wrong (ANSWER=RES^0x01) -> DONE=1, SCORE=5, ROUND=8. START in OVER restarts with SCORE=0, ROUND=1.
5. Reset mid-ASK: RST during round 4 -> next cycle IDLE, SCORE=0, ROUND=0, no CORRECT/WRONG pulse.
6. STREAK_BONUS_EN defined: 3 correct in a row -> SCORE 0,1,2,4. Then wrong, then correct -> SCORE 5.

Source files
------------

// File: rtl/quiz_round_ctrl_if.sv
// quiz_round_ctrl_if: quiz round controller bundle; master = controller, slave = player/ALU side
interface quiz_round_ctrl_if;
  logic START, SUBMIT;
  logic [7:0] ANSWER, RES, A, B;
  logic [3:0] MODE, ROUND, TIME_LEFT;
  logic [4:0] SCORE;
  logic BUSY, CORRECT, WRONG, DONE;
  modport master (input START, SUBMIT, ANSWER, RES,
                  output A, B, MODE, SCORE, ROUND, TIME_LEFT, BUSY, CORRECT, WRONG, DONE);
  modport slave (output START, SUBMIT, ANSWER, RES,
                 input A, B, MODE, SCORE, ROUND, TIME_LEFT, BUSY, CORRECT, WRONG, DONE);
endinterface

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: quick-math round sequencer (LFSR operands, timed answer check, score); STREAK_BONUS_EN adds streak bonus
module quiz_round_ctrl #(
  parameter int ROUNDS = 8,
  parameter int TICKS_PER_SEC = 50000000,
  parameter int ROUND_SECONDS = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic CLK,
  input logic RST,
  quiz_round_ctrl_if.master bus
);
  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  typedef enum logic [2:0] {IDLE, GEN, ASK, JUDGE, OVER} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0] a_q, a_d, b_q, b_d, ans_q, ans_d;
  logic [3:0] mode_q, mode_d, round_q, round_d, tl_q, tl_d;
  logic [4:0] score_q, score_d;
  logic [TW-1:0] tick_q, tick_d;
  logic answered_q, answered_d, correct_q, correct_d, wrong_q, wrong_d;
  logic busy_q, busy_d, done_q, done_d, wrap, hit;
`ifdef STREAK_BONUS_EN
  logic [1:0] streak_q, streak_d;
`endif
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    ans_d = ans_q;
    mode_d = mode_q;
    round_d = round_q;
    tl_d = tl_q;
    score_d = score_q;
    tick_d = tick_q;
    answered_d = answered_q;
    correct_d = 1'b0;
    wrong_d = 1'b0;
`ifdef STREAK_BONUS_EN
    streak_d = streak_q;
`endif
    wrap = tick_q == TW'(TICKS_PER_SEC - 1);
    hit = answered_q && ans_q == bus.RES;
    case (state_q)
      IDLE, OVER: if (bus.START) begin
        state_d = GEN;
        round_d = 4'd1;
        score_d = 5'd0;
`ifdef STREAK_BONUS_EN
        streak_d = 2'd0;
`endif
      end
      GEN: begin
        a_d = lfsr_q[7:0];
        b_d = lfsr_q[15:8];
        mode_d = 4'b1000 >> lfsr_q[9:8];
        tl_d = 4'(ROUND_SECONDS);
        tick_d = '0;
        state_d = ASK;
      end
      ASK: begin
        tick_d = wrap ? '0 : tick_q + 1'b1;
        tl_d = wrap ? tl_q - 4'd1 : tl_q;
        answered_d = bus.SUBMIT;
        ans_d = bus.SUBMIT ? bus.ANSWER : ans_q;
        state_d = (bus.SUBMIT || (wrap && tl_q == 4'd1)) ? JUDGE : ASK;
      end
      JUDGE: begin
        correct_d = hit;
        wrong_d = !hit;
`ifdef STREAK_BONUS_EN
        score_d = hit ? score_q + (streak_q == 2'd2 ? 5'd2 : 5'd1) : score_q;
        streak_d = (hit && streak_q != 2'd2) ? streak_q + 2'd1 : 2'd0;
`else
        score_d = hit ? score_q + 5'd1 : score_q;
`endif
        state_d = round_q == 4'(ROUNDS) ? OVER : GEN;
        round_d = round_q == 4'(ROUNDS) ? round_q : round_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == GEN || state_d == ASK || state_d == JUDGE;
    done_d = state_d == OVER;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      lfsr_q <= SEED;
      a_q <= '0;
      b_q <= '0;
      ans_q <= '0;
      mode_q <= '0;
      round_q <= '0;
      tl_q <= '0;
      score_q <= '0;
      tick_q <= '0;
      answered_q <= 1'b0;
      correct_q <= 1'b0;
      wrong_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      a_q <= a_d;
      b_q <= b_d;
      ans_q <= ans_d;
      mode_q <= mode_d;
      round_q <= round_d;
      tl_q <= tl_d;
      score_q <= score_d;
      tick_q <= tick_d;
      answered_q <= answered_d;
      correct_q <= correct_d;
      wrong_q <= wrong_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef STREAK_BONUS_EN
      streak_q <= streak_d;
`endif
    end
  end
  assign bus.A = a_q;
  assign bus.B = b_q;
  assign bus.MODE = mode_q;
  assign bus.SCORE = score_q;
  assign bus.ROUND = round_q;
  assign bus.TIME_LEFT = tl_q;
  assign bus.BUSY = busy_q;
  assign bus.CORRECT = correct_q;
  assign bus.WRONG = wrong_q;
  assign bus.DONE = done_q;
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb_quiz_round_ctrl: randomized scoreboard bench for quiz_round_ctrl
module tb_quiz_round_ctrl;
  localparam int NR = 8, TPS = 4, RS = 3;
  typedef struct {logic c; logic [4:0] s; logic [3:0] r; logic d;} exp_t;
  logic CLK = 1'b0, RST = 1'b1;
  int checks = 0, errors = 0, cyc = 0;
  int m_score, m_round, m_streak;
  exp_t q[$];
  exp_t mon_e;
  always #5 CLK = ~CLK;
  quiz_round_ctrl_if bus();
  quiz_round_ctrl #(.ROUNDS(NR), .TICKS_PER_SEC(TPS), .ROUND_SECONDS(RS), .LFSR_SEED(16'hACE1))
    dut (.CLK(CLK), .RST(RST), .bus(bus));
  always_comb begin
    case (bus.MODE)
      4'b1000: bus.RES = bus.A + bus.B;
      4'b0100: bus.RES = bus.A - bus.B;
      4'b0010: bus.RES = bus.A ^ bus.B;
      4'b0001: bus.RES = {bus.A[6:0], 1'b0};
      default: bus.RES = 8'h00;
    endcase
  end
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] x;
    x = 16'hACE1;
    for (int i = 0; i < n; i++) x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    return x;
  endfunction
  always @(negedge CLK) begin
    if (!RST && (bus.CORRECT || bus.WRONG)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {bus.CORRECT, bus.WRONG}, 0);
      end else begin
        mon_e = q.pop_front();
        chk("pulse", {bus.CORRECT, bus.WRONG}, {mon_e.c, !mon_e.c});
        chk("score", bus.SCORE, mon_e.s);
        chk("round", bus.ROUND, mon_e.r);
        chk("done", bus.DONE, mon_e.d);
      end
    end
  end
  task automatic expect_judge(input bit ok);
    exp_t e;
    if (ok) begin
`ifdef STREAK_BONUS_EN
      if (m_streak == 2) begin
        m_score += 2;
        m_streak = 0;
      end else begin
        m_score++;
        m_streak++;
      end
`else
      m_score++;
`endif
    end else m_streak = 0;
    e.c = ok;
    e.s = 5'(m_score);
    e.d = m_round == NR;
    if (m_round < NR) m_round++;
    e.r = 4'(m_round);
    q.push_back(e);
  endtask
  task automatic check_idle(input string tag);
    chk({tag, "_a"}, bus.A, 0);
    chk({tag, "_b"}, bus.B, 0);
    chk({tag, "_mode"}, bus.MODE, 0);
    chk({tag, "_score"}, bus.SCORE, 0);
    chk({tag, "_round"}, bus.ROUND, 0);
    chk({tag, "_tl"}, bus.TIME_LEFT, 0);
    chk({tag, "_flags"}, {bus.BUSY, bus.CORRECT, bus.WRONG, bus.DONE}, 0);
  endtask
  // kind: 0 correct, 1 wrong, 2 timeout, 3 correct on final wrap; entered on the GEN cycle
  task automatic play_round(input int kind, input bit abort);
    logic [15:0] l;
    int w;
    l = lfsr_at(cyc);
    chk("gen_busy", bus.BUSY, 1);
    @(negedge CLK);
    chk("op_a", bus.A, l[7:0]);
    chk("op_b", bus.B, l[15:8]);
    chk("op_mode", bus.MODE, 4'b1000 >> l[9:8]);
    w = kind == 3 ? TPS * RS - 1 : kind == 2 ? TPS * RS : $urandom_range(0, TPS * RS - 1);
    for (int i = 0; i < w; i++) begin
      chk("time_left", bus.TIME_LEFT, RS - i / TPS);
      @(negedge CLK);
    end
    if (abort) begin
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check_idle("abort");
      m_score = 0;
      m_round = 0;
      m_streak = 0;
      repeat (5) @(negedge CLK);
      chk("abort_busy", bus.BUSY, 0);
      return;
    end
    if (kind == 2) begin
      chk("timeout_tl", bus.TIME_LEFT, 0);
      expect_judge(1'b0);
    end else begin
      bus.SUBMIT = 1'b1;
      bus.ANSWER = kind == 1 ? bus.RES ^ 8'($urandom_range(1, 255)) : bus.RES;
      expect_judge(kind != 1);
      @(negedge CLK);
      bus.SUBMIT = 1'b0;
    end
    @(negedge CLK);
    #1;
    chk("judge_latency", q.size(), 0);
  endtask
  task automatic play_game(input int kinds[NR], input int abort_round);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    m_score = 0;
    m_round = 1;
    m_streak = 0;
    chk("start_round", bus.ROUND, 1);
    chk("start_score", bus.SCORE, 0);
    chk("start_done", bus.DONE, 0);
    for (int r = 1; r <= NR; r++) begin
      if (r == abort_round) begin
        play_round(0, 1'b1);
        return;
      end
      play_round(kinds[r-1], 1'b0);
    end
    repeat (3) begin
      bus.SUBMIT = 1'b1;
      @(negedge CLK);
      bus.SUBMIT = 1'b0;
    end
    chk("over_done", bus.DONE, 1);
    chk("over_busy", bus.BUSY, 0);
    chk("over_round", bus.ROUND, NR);
    chk("over_score", bus.SCORE, m_score);
  endtask
  initial begin
    int rnd[NR];
    bus.START = 1'b0;
    bus.SUBMIT = 1'b0;
    bus.ANSWER = 8'h00;
    repeat (2) @(negedge CLK);
    check_idle("reset");
    RST = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.SUBMIT = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    bus.SUBMIT = 1'b0;
    check_idle("idle");
    play_game('{0, 1, 0, 3, 2, 0, 1, 0}, 0);
    chk("game1_score", bus.SCORE, 5);
    for (int i = 0; i < NR; i++) rnd[i] = $urandom_range(0, 3);
    play_game(rnd, 4);
    for (int i = 0; i < NR; i++) rnd[i] = $urandom_range(0, 3);
    play_game(rnd, 0);
    play_game('{0, 0, 0, 1, 0, 3, 0, 0}, 0);
    repeat (3) @(negedge CLK);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
